mult_issue_ctrl: RTL and testbench
==================================

// Module: mult_issue_ctrl
// PURPOSE
// - Issue/complete controller directly upstream of the 64-bit iterative multiplier.
// - Accepts one tagged multiply op from the reservation station over a valid/ready handshake.
// - Launches the multiplier with a single-cycle valid_in pulse and waits for its done level.
// - Holds the product and tag on the CDB request port until granted; supports pipeline flush.
// PARAMETERS
// - DATA_W       64  operand/product width (multiplier keeps low DATA_W bits)
// - TAG_W        6   ROB/physical-register tag width
// - TIMEOUT_CYC  8   max cycles in WAIT/DRAIN before timeout (used only with MULT_ISSUE_TIMEOUT_EN)
// PORTS
// - clk          in   1       rising-edge clock
// - rst          in   1       asynchronous, active-high reset
// - issue_valid  in   1       RS presents an op
// - issue_ready  out  1       controller can accept; transfer = issue_valid & issue_ready
// - issue_a      in   DATA_W  operand A
// - issue_b      in   DATA_W  operand B
// - issue_tag    in   TAG_W   destination tag
// - flush        in   1       squash any op held or in flight
// - mul_a        out  DATA_W  registered operand A to multiplier
// - mul_b        out  DATA_W  registered operand B to multiplier
// - mul_valid_in out  1       one-cycle launch pulse to multiplier
// - mul_out      in   DATA_W  multiplier product
// - mul_valid_out in  1       multiplier done (level; stays high until next launch)
// - cdb_req      out  1       result available for broadcast
// - cdb_grant    in   1       CDB arbiter grant; consumes result this cycle
// - cdb_data     out  DATA_W  registered product
// - cdb_tag      out  TAG_W   registered tag
// - timeout_err  out  1       sticky timeout flag (constant 0 unless MULT_ISSUE_TIMEOUT_EN)
// BEHAVIOUR
// - Reset (async): state=IDLE; mul_a/b, cdb_data, cdb_tag, timeout_err = 0; mul_valid_in = 0; cdb_req = 0.
// - issue_ready is forced to 0 while rst is high.
// - FSM states: IDLE, LAUNCH, WAIT, RESULT, DRAIN.
// - issue_ready = (IDLE | (RESULT & cdb_grant)) & ~flush.
// - IDLE: on accept, register issue_a/b into mul_a/b and issue_tag into the tag register; go to LAUNCH.
// - LAUNCH: mul_valid_in = 1 for exactly this cycle; go to WAIT.
// - WAIT: on mul_valid_out, register mul_out into cdb_data, drive cdb_tag, go to RESULT.
//   - The stale done level cannot be seen here: the multiplier leaves done on the launch edge.
// - RESULT: cdb_req = 1; data and tag are held stable until a grant.
//   - On cdb_grant with no new accept: go to IDLE.
//   - On cdb_grant with a same-cycle accept: capture the new op and go to LAUNCH (back-to-back).
// - Latency: accept at edge N -> launch edge N+1 -> mul_valid_out high after N+5 -> cdb_req high after N+6.
//   - Minimum issue-to-issue interval is 7 cycles.
// - flush (priority over all other events):
//   - IDLE: no effect.
//   - RESULT: result dropped, even if cdb_grant is high the same cycle; go to IDLE.
//   - LAUNCH/WAIT: go to DRAIN, because the multiplier is still running and ignores new valid_in.
// - DRAIN: issue_ready = 0, cdb_req = 0; on mul_valid_out go to IDLE, discarding the product.
//   - flush while in DRAIN: stay in DRAIN.
// - mul_valid_in is never asserted outside LAUNCH, so at most one op is in flight.
// - Widths: no arithmetic in this block; product truncation is the multiplier's job.
// CONFIGURATION
// - MULT_ISSUE_TIMEOUT_EN defined:
//   - A cycle counter runs in WAIT/DRAIN and clears on entry to either state.
//   - If TIMEOUT_CYC cycles pass without mul_valid_out: set timeout_err (sticky until rst), go to IDLE, drop the op, no cdb_req.
// - MULT_ISSUE_TIMEOUT_EN undefined:
//   - No counter; timeout_err is tied to 0.
//   - WAIT/DRAIN wait indefinitely for mul_valid_out.
// TESTING
// - Reset mid-WAIT: assert rst async -> next sample shows state IDLE, cdb_req = 0, mul_valid_in = 0, issue_ready = 1 after release.
// - Single op (a=3, b=5, tag=0x12), grant held high -> mul_valid_in pulses 1 cycle; cdb_req rises 6 cycles after accept.
//   - Required values: cdb_data = 15, cdb_tag = 0x12; cdb_req drops the cycle after grant.
// - Grant withheld 4 cycles (a=b=0xFFFF_FFFF_FFFF_FFFF) -> cdb_req held; cdb_data = 1 stable throughout; issue_ready = 0.
// - Back-to-back: RESULT with cdb_grant and issue_valid in the same cycle (a=2, b=7) -> new op captured, LAUNCH next cycle, later cdb_data = 14.
// - Flush during WAIT (2 cycles after launch) -> DRAIN; issue_ready = 0 until mul_valid_out, then IDLE.
//   - Required: no cdb_req at any point; the next op (a=4, b=4) returns 16.
// - Timeout (macro on, TIMEOUT_CYC = 8): hold mul_valid_out = 0 -> timeout_err = 1 after 8 WAIT cycles; state IDLE; no cdb_req.

Source files
------------

// File: rtl/mult_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// mult_issue_ctrl_if
// Bundles the signals of the multiply issue/complete controller:
//   issue_*   : valid/ready op transfer from the reservation station
//   flush     : pipeline squash
//   mul_*     : launch/done link to the iterative multiplier
//   cdb_*     : result broadcast request/grant with product and tag
//   timeout_err : sticky multiplier timeout flag
// Modports:
//   master : the controller (drives issue_ready, mul_*, cdb_req/data/tag)
//   slave  : the environment (RS, multiplier, CDB arbiter)
// ----------------------------------------------------------------------------
interface mult_issue_ctrl_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 6
);
    logic              issue_valid;
    logic              issue_ready;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic [TAG_W-1:0]  issue_tag;
    logic              flush;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic              mul_valid_in;
    logic [DATA_W-1:0] mul_out;
    logic              mul_valid_out;
    logic              cdb_req;
    logic              cdb_grant;
    logic [DATA_W-1:0] cdb_data;
    logic [TAG_W-1:0]  cdb_tag;
    logic              timeout_err;

    modport master (
        input  issue_valid, issue_a, issue_b, issue_tag, flush,
        input  mul_out, mul_valid_out, cdb_grant,
        output issue_ready, mul_a, mul_b, mul_valid_in,
        output cdb_req, cdb_data, cdb_tag, timeout_err
    );

    modport slave (
        output issue_valid, issue_a, issue_b, issue_tag, flush,
        output mul_out, mul_valid_out, cdb_grant,
        input  issue_ready, mul_a, mul_b, mul_valid_in,
        input  cdb_req, cdb_data, cdb_tag, timeout_err
    );
endinterface

// File: rtl/mult_issue_ctrl.sv
// ----------------------------------------------------------------------------
// mult_issue_ctrl
// Issue/complete controller sitting in front of a 64-bit iterative multiplier.
// Accepts one tagged op, launches the multiplier with a one-cycle pulse, waits
// for its done level, then holds product and tag on the CDB until granted.
// A flush squashes any held or in-flight op; an op already inside the
// multiplier is drained (product discarded) before new work is accepted.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mult_issue_ctrl_if.master (issue, flush, multiplier, CDB, timeout)
//
// Optional feature macro: MULT_ISSUE_TIMEOUT_EN
//   defined   : WAIT/DRAIN abort after TIMEOUT_CYC cycles without done,
//               setting the sticky timeout_err and returning to IDLE.
//   undefined : no counter, timeout_err tied low, waits are unbounded.
// ----------------------------------------------------------------------------
module mult_issue_ctrl #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned TAG_W       = 6,
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input logic               clk,
    input logic               rst,
    mult_issue_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StResult,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] mul_a_q, mul_b_q, cdb_data_q;
    logic [TAG_W-1:0]  tag_q, cdb_tag_q;
    logic              accept;
    logic              timeout;

    // ------------------------------------------------------------------
    // Optional timeout counter
    // ------------------------------------------------------------------
`ifdef MULT_ISSUE_TIMEOUT_EN
    localparam int unsigned CntW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_err_q;
    logic            in_wait_drain;

    assign in_wait_drain = (state_q == StWait) || (state_q == StDrain);
    assign timeout       = in_wait_drain && !bus.mul_valid_out && (cnt_q == CntLast);

    // Cleared on any entry into WAIT/DRAIN (including WAIT->DRAIN); saturates
    // so a long flush in DRAIN cannot wrap past the limit.
    always_comb begin
        cnt_d = '0;
        if (((state_d == StWait) || (state_d == StDrain)) && (state_d == state_q)) begin
            cnt_d = (cnt_q == CntLast) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_q | timeout;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
    assign bus.timeout_err    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (flush wins over every other event)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StLaunch;
            end
            StLaunch: begin
                state_d = bus.flush ? StDrain : StWait;
            end
            StWait: begin
                if (bus.flush)              state_d = StDrain;
                else if (bus.mul_valid_out) state_d = StResult;
                else if (timeout)           state_d = StIdle;
            end
            StResult: begin
                if (bus.flush)          state_d = StIdle;
                else if (bus.cdb_grant) state_d = accept ? StLaunch : StIdle;
            end
            StDrain: begin
                if (bus.flush)                         state_d = StDrain;
                else if (bus.mul_valid_out || timeout) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.issue_ready  = 1'b0;
        bus.mul_valid_in = 1'b0;
        bus.cdb_req      = 1'b0;
        if (!rst && !bus.flush) begin
            bus.issue_ready = (state_q == StIdle) || ((state_q == StResult) && bus.cdb_grant);
        end
        bus.mul_valid_in = (state_q == StLaunch);
        bus.cdb_req      = (state_q == StResult);
    end

    assign accept = bus.issue_valid && bus.issue_ready;

    // ------------------------------------------------------------------
    // Operand / result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            tag_q      <= '0;
            cdb_data_q <= '0;
            cdb_tag_q  <= '0;
        end else begin
            if (accept) begin
                mul_a_q <= bus.issue_a;
                mul_b_q <= bus.issue_b;
                tag_q   <= bus.issue_tag;
            end
            if ((state_q == StWait) && bus.mul_valid_out && !bus.flush) begin
                cdb_data_q <= bus.mul_out;
                cdb_tag_q  <= tag_q;
            end
        end
    end

    assign bus.mul_a    = mul_a_q;
    assign bus.mul_b    = mul_b_q;
    assign bus.cdb_data = cdb_data_q;
    assign bus.cdb_tag  = cdb_tag_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
module tb_mult_issue_ctrl;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned TAG_W  = 6;
    localparam int          LAT    = 6;  // accept edge -> cdb_req visible

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mul_stall = 1'b0;
    int   mdl_cnt;
    int   n_checks = 0;
    int   n_fail   = 0;

    mult_issue_ctrl_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    mult_issue_ctrl #(.DATA_W(DATA_W), .TAG_W(TAG_W), .TIMEOUT_CYC(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Iterative multiplier stand-in: done rises 4 edges after the launch edge
    // and stays high until the next launch.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_cnt           <= 0;
            bus.mul_valid_out <= 1'b0;
            bus.mul_out       <= '0;
        end else if (bus.mul_valid_in) begin
            bus.mul_valid_out <= 1'b0;
            mdl_cnt           <= mul_stall ? 0 : 4;
            bus.mul_out       <= bus.mul_a * bus.mul_b;
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) bus.mul_valid_out <= 1'b1;
        end
    end

    // Reference: product of the operands as issued, low DATA_W bits.
    function automatic logic [DATA_W-1:0] ref_prod(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] full;
        full = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        return full[DATA_W-1:0];
    endfunction

    // Present an op and wait (bounded) for the transfer; returns at the
    // negedge right after the accepting edge (LAUNCH cycle).
    task automatic issue(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [TAG_W-1:0] tag, output bit ok);
        int w = 0;
        bus.issue_valid = 1'b1;
        bus.issue_a     = a;
        bus.issue_b     = b;
        bus.issue_tag   = tag;
        #1;
        while (bus.issue_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        ok = (bus.issue_ready === 1'b1);
        @(negedge clk);
        bus.issue_valid = 1'b0;
    endtask

    // Count cycles from the LAUNCH negedge to cdb_req, and launch pulses seen.
    task automatic wait_req(output int lat, output int pulses);
        lat    = 0;
        pulses = 0;
        while (bus.cdb_req !== 1'b1 && lat < 40) begin
            if (bus.mul_valid_in === 1'b1) pulses++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        bit ok;
        bit seen;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low: got %b exp 0", bus.issue_ready); end
        n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL rst_cdb_req: got %b exp 0", bus.cdb_req); end
        n_checks++; if (bus.mul_valid_in !== 1'b0) begin n_fail++; $display("FAIL rst_valid_in: got %b exp 0", bus.mul_valid_in); end
        n_checks++; if (bus.cdb_data !== '0 || bus.mul_a !== '0 || bus.cdb_tag !== '0) begin n_fail++; $display("FAIL rst_regs: data %h a %h tag %h exp 0", bus.cdb_data, bus.mul_a, bus.cdb_tag); end
        n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b exp 0", bus.timeout_err); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b exp 1", bus.issue_ready); end
        // Reset in the middle of WAIT.
        issue(64'd11, 64'd13, 6'h05, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_issue_accept: got no accept exp accept"); end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.cdb_req !== 1'b0 || bus.mul_valid_in !== 1'b0 || bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wait: req %b vin %b rdy %b exp 0 0 0", bus.cdb_req, bus.mul_valid_in, bus.issue_ready); end
        n_checks++; if (bus.mul_a !== '0) begin n_fail++; $display("FAIL rst_mid_wait_mul_a: got %h exp 0", bus.mul_a); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_wait_ready: got %b exp 1", bus.issue_ready); end
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (bus.cdb_req !== 1'b0) seen = 1'b1; end
        n_checks++; if (seen) begin n_fail++; $display("FAIL rst_no_req: got req exp none"); end
    endtask

    task automatic test_single();
        bit ok;
        int lat, pulses;
        bus.cdb_grant = 1'b1;
        issue(64'd3, 64'd5, 6'h12, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_accept: got no accept exp accept"); end
        n_checks++; if (bus.mul_a !== 64'd3 || bus.mul_b !== 64'd5) begin n_fail++; $display("FAIL single_operands: got %0d %0d exp 3 5", bus.mul_a, bus.mul_b); end
        wait_req(lat, pulses);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL single_latency: got %0d exp %0d", lat, LAT); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL single_pulses: got %0d exp 1", pulses); end
        n_checks++; if (bus.cdb_data !== ref_prod(64'd3, 64'd5)) begin n_fail++; $display("FAIL single_data: got %0d exp %0d", bus.cdb_data, ref_prod(64'd3, 64'd5)); end
        n_checks++; if (bus.cdb_tag !== 6'h12) begin n_fail++; $display("FAIL single_tag: got %h exp 12", bus.cdb_tag); end
        @(negedge clk);
        n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %b exp 0", bus.cdb_req); end
        bus.cdb_grant = 1'b0;
    endtask

    task automatic test_grant_hold();
        bit ok;
        int lat, pulses;
        logic [DATA_W-1:0] ones;
        logic [TAG_W-1:0]  tag;
        bit bad;
        ones = '1;
        tag  = TAG_W'($urandom);
        bus.cdb_grant = 1'b0;
        issue(ones, ones, tag, ok);
        wait_req(lat, pulses);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL hold_latency: got %0d exp %0d", lat, LAT); end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.cdb_req !== 1'b1 || bus.cdb_data !== ref_prod(ones, ones) ||
                bus.cdb_tag !== tag || bus.issue_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL hold_stable: got req %b data %h rdy %b exp 1 %h 0", bus.cdb_req, bus.cdb_data, bus.issue_ready, ref_prod(ones, ones)); end
        bus.cdb_grant = 1'b1;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL hold_grant_ready: got %b exp 1", bus.issue_ready); end
        @(negedge clk);
        n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL hold_req_drop: got %b exp 0", bus.cdb_req); end
        bus.cdb_grant = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat, pulses;
        issue(64'd9, 64'd9, 6'h01, ok);
        wait_req(lat, pulses);
        bus.cdb_grant   = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_a     = 64'd2;
        bus.issue_b     = 64'd7;
        bus.issue_tag   = 6'h2a;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b exp 1", bus.issue_ready); end
        n_checks++; if (bus.cdb_data !== ref_prod(64'd9, 64'd9)) begin n_fail++; $display("FAIL b2b_first_data: got %0d exp 81", bus.cdb_data); end
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.cdb_grant   = 1'b0;
        n_checks++; if (bus.mul_valid_in !== 1'b1 || bus.cdb_req !== 1'b0 || bus.mul_a !== 64'd2) begin n_fail++; $display("FAIL b2b_launch: got vin %b req %b a %0d exp 1 0 2", bus.mul_valid_in, bus.cdb_req, bus.mul_a); end
        wait_req(lat, pulses);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d exp %0d", lat, LAT); end
        n_checks++; if (bus.cdb_data !== ref_prod(64'd2, 64'd7) || bus.cdb_tag !== 6'h2a) begin n_fail++; $display("FAIL b2b_data: got %0d tag %h exp 14 tag 2a", bus.cdb_data, bus.cdb_tag); end
        bus.cdb_grant = 1'b1;
        @(negedge clk);
        bus.cdb_grant = 1'b0;
    endtask

    task automatic test_flush();
        bit ok;
        bit seen;
        int k, lat, pulses;
        bus.cdb_grant = 1'b0;
        issue({$urandom, $urandom}, {$urandom, $urandom}, 6'h33, ok);
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b exp 0", bus.issue_ready); end
        @(negedge clk);
        bus.flush = 1'b0;
        k    = 3;
        seen = 1'b0;
        #1;
        while (bus.issue_ready !== 1'b1 && k < 20) begin
            if (bus.cdb_req !== 1'b0) seen = 1'b1;
            @(negedge clk);
            k++;
            #1;
        end
        n_checks++; if (k != LAT) begin n_fail++; $display("FAIL flush_drain_len: got ready at %0d exp %0d", k, LAT); end
        n_checks++; if (seen) begin n_fail++; $display("FAIL flush_no_req: got req exp none"); end
        bus.cdb_grant = 1'b1;
        issue(64'd4, 64'd4, 6'h07, ok);
        wait_req(lat, pulses);
        n_checks++; if (bus.cdb_data !== ref_prod(64'd4, 64'd4) || lat != LAT) begin n_fail++; $display("FAIL flush_next_op: got %0d lat %0d exp 16 lat %0d", bus.cdb_data, lat, LAT); end
        @(negedge clk);
        bus.cdb_grant = 1'b0;
    endtask

    task automatic test_flush_result();
        bit ok;
        bit seen;
        int lat, pulses;
        issue(64'd6, 64'd6, 6'h15, ok);
        wait_req(lat, pulses);
        bus.flush     = 1'b1;
        bus.cdb_grant = 1'b1;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL flres_ready: got %b exp 0", bus.issue_ready); end
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.cdb_grant = 1'b0;
        #1;
        n_checks++; if (bus.cdb_req !== 1'b0 || bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL flres_idle: got req %b rdy %b exp 0 1", bus.cdb_req, bus.issue_ready); end
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (bus.cdb_req !== 1'b0) seen = 1'b1; end
        n_checks++; if (seen) begin n_fail++; $display("FAIL flres_no_req: got req exp none"); end
    endtask

    task automatic test_random();
        bit ok;
        int lat, pulses, dly;
        bit bad;
        logic [DATA_W-1:0] a, b;
        logic [TAG_W-1:0]  tag;
        for (int n = 0; n < 16; n++) begin
            a   = {$urandom, $urandom};
            b   = (n % 4 == 0) ? 64'(1) << $urandom_range(63) : {$urandom, $urandom};
            tag = TAG_W'($urandom);
            dly = $urandom_range(3);
            issue(a, b, tag, ok);
            wait_req(lat, pulses);
            n_checks++; if (!ok || lat != LAT || pulses != 1) begin n_fail++; $display("FAIL rand_timing[%0d]: got ok %b lat %0d pulses %0d exp 1 %0d 1", n, ok, lat, pulses, LAT); end
            n_checks++; if (bus.cdb_data !== ref_prod(a, b) || bus.cdb_tag !== tag) begin n_fail++; $display("FAIL rand_data[%0d]: got %h/%h exp %h/%h", n, bus.cdb_data, bus.cdb_tag, ref_prod(a, b), tag); end
            bad = 1'b0;
            repeat (dly) begin
                @(negedge clk);
                if (bus.cdb_req !== 1'b1 || bus.cdb_data !== ref_prod(a, b)) bad = 1'b1;
            end
            bus.cdb_grant = 1'b1;
            @(negedge clk);
            bus.cdb_grant = 1'b0;
            n_checks++; if (bad || bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL rand_grant[%0d]: got hold_bad %b req %b exp 0 0", n, bad, bus.cdb_req); end
        end
    endtask

    task automatic test_timeout();
`ifdef MULT_ISSUE_TIMEOUT_EN
        bit ok;
        bit bad;
        int lat, pulses;
        mul_stall = 1'b1;
        issue(64'd5, 64'd5, 6'h3c, ok);
        bad = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.timeout_err !== 1'b0 || bus.cdb_req !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL timeout_early: got err/req before 8 wait cycles exp none"); end
        @(negedge clk);
        #1;
        n_checks++; if (bus.timeout_err !== 1'b1 || bus.issue_ready !== 1'b1 || bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL timeout_fire: got err %b rdy %b req %b exp 1 1 0", bus.timeout_err, bus.issue_ready, bus.cdb_req); end
        mul_stall = 1'b0;
        issue(64'd8, 64'd3, 6'h01, ok);
        wait_req(lat, pulses);
        n_checks++; if (bus.cdb_data !== ref_prod(64'd8, 64'd3) || bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_after: got %0d err %b exp 24 err 1", bus.cdb_data, bus.timeout_err); end
        bus.cdb_grant = 1'b1;
        @(negedge clk);
        bus.cdb_grant = 1'b0;
`else
        n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_tied: got %b exp 0", bus.timeout_err); end
`endif
    endtask

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_a     = '0;
        bus.issue_b     = '0;
        bus.issue_tag   = '0;
        bus.flush       = 1'b0;
        bus.cdb_grant   = 1'b0;
        test_reset();
        test_single();
        test_grant_hold();
        test_back_to_back();
        test_flush();
        test_flush_result();
        test_random();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
